// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared types and constants for the calculator BCD datapath.
//   digito_bcd_t : one packed BCD digit (4 bits)
//   BCD_MAX      : largest legal BCD digit value
//   estado_sub_t : state encoding of the serial BCD subtractor
// ---------------------------------------------------------------------------
package calc_pkg;

   typedef logic [3:0] digito_bcd_t;

   localparam digito_bcd_t BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      OCIOSO,
      SUBTRAI,
      COMPLEMENTA,
      PRONTO
   } estado_sub_t;

endpackage

// File: rtl/digito_sub_bcd.sv
// ---------------------------------------------------------------------------
// digito_sub_bcd
// Combinational single-digit BCD subtract with borrow: d = a - b - bin,
// corrected back into 0..9 by adding ten when the raw difference is negative.
// Ports:
//   a, b  : minuend and subtrahend digits
//   bin   : borrow in from the less significant digit
//   d     : result digit
//   bout  : borrow out to the next more significant digit
// ---------------------------------------------------------------------------
module digito_sub_bcd
   import calc_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bin,
   output logic [3:0] d,
   output logic       bout
);

   logic [4:0] diferenca;

   // Five bits cover the full range -16..15 even for non-BCD digits, so
   // bit 4 is a reliable sign bit for the borrow decision.
   always_comb begin
      diferenca = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
      d         = diferenca[3:0];
      bout      = 1'b0;
      if (diferenca[4]) begin
         d    = diferenca[3:0] + 4'd10;
         bout = 1'b1;
      end
   end

endmodule

// File: rtl/subtrai_bcd_serial.sv
// ---------------------------------------------------------------------------
// subtrai_bcd_serial
// Digit-serial BCD subtractor, LSD first: S = |A - B| in sign-magnitude BCD.
// A first pass subtracts digit by digit; if the final borrow is set the
// stored result is a ten's complement, so a second pass computes 0 - r to
// recover the magnitude and reports negativo.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   agora      : start pulse, A and B captured on the same edge
//   A, B       : packed BCD operands, digit 0 in bits [3:0]
//   ocupado    : high while a subtraction pass is running
//   valido     : one-cycle pulse when S/negativo/erro hold a new result
//   S          : magnitude of A - B, held until the next result
//   negativo   : 1 when A < B, held with S
//   erro       : invalid-digit flag
// Optional feature macro: SUBTRAI_BCD_VALIDA_EN enables the input digit
// check; when undefined erro is tied to 0.
// ---------------------------------------------------------------------------
module subtrai_bcd_serial
   import calc_pkg::*;
#(
   parameter int DIGITOS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 agora,
   input  logic [4*DIGITOS-1:0] A,
   input  logic [4*DIGITOS-1:0] B,
   output logic                 ocupado,
   output logic                 valido,
   output logic [4*DIGITOS-1:0] S,
   output logic                 negativo,
   output logic                 erro
);

   localparam int W  = 4 * DIGITOS;
   localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;

   estado_sub_t estado;
   estado_sub_t proximo;

   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [W-1:0]  res;
   logic [W-1:0]  res_next;
   logic          borrow;
   logic [IW-1:0] idx;
   logic          ultimo;
   logic          inicia;
   logic          invalido;
   logic          carrega_s;
   logic [3:0]    op_a;
   logic [3:0]    op_b;
   logic [3:0]    dig;
   logic          bout;

   assign ultimo = (idx == IW'(DIGITOS - 1));
   assign inicia = agora && ((estado == OCIOSO) || (estado == PRONTO));

   // A real result lands on S when the last digit of the final pass is done.
   assign carrega_s = ultimo && (((estado == SUBTRAI) && !bout) ||
                                 (estado == COMPLEMENTA));

`ifdef SUBTRAI_BCD_VALIDA_EN
   function automatic logic tem_invalido(input logic [W-1:0] x,
                                         input logic [W-1:0] y);
      logic r;
      r = 1'b0;
      for (int i = 0; i < DIGITOS; i++) begin
         if ((x[4*i +: 4] > BCD_MAX) || (y[4*i +: 4] > BCD_MAX)) begin
            r = 1'b1;
         end
      end
      return r;
   endfunction

   assign invalido = tem_invalido(A, B);
`else
   assign invalido = 1'b0;
`endif

   // The complement pass subtracts the stored result from zero; the single
   // digit unit is shared by both passes.
   always_comb begin
      op_a = a_sh[3:0];
      op_b = b_sh[3:0];
      if (estado == COMPLEMENTA) begin
         op_a = 4'd0;
         op_b = res[3:0];
      end
   end

   digito_sub_bcd u_digito (
      .a    (op_a),
      .b    (op_b),
      .bin  (borrow),
      .d    (dig),
      .bout (bout)
   );

   // Result digits enter at the top and shift down, so after DIGITOS cycles
   // digit 0 sits in bits [3:0].
   generate
      if (DIGITOS == 1) begin : g_um
         assign res_next = dig;
      end else begin : g_varios
         assign res_next = {dig, res[W-1:4]};
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado <= OCIOSO;
      end else begin
         estado <= proximo;
      end
   end

   // Next-state logic; a start request is honoured in OCIOSO and PRONTO.
   always_comb begin
      proximo = estado;
      unique case (estado)
         OCIOSO, PRONTO: begin
            if (inicia) begin
               proximo = invalido ? PRONTO : SUBTRAI;
            end else begin
               proximo = OCIOSO;
            end
         end
         SUBTRAI: begin
            if (ultimo) begin
               proximo = bout ? COMPLEMENTA : PRONTO;
            end
         end
         COMPLEMENTA: begin
            if (ultimo) begin
               proximo = PRONTO;
            end
         end
         default: proximo = OCIOSO;
      endcase
   end

   assign ocupado = (estado == SUBTRAI) || (estado == COMPLEMENTA);
   assign valido  = (estado == PRONTO);

   // Datapath: operand capture, digit shifting, borrow chain and result load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh     <= '0;
         b_sh     <= '0;
         res      <= '0;
         borrow   <= 1'b0;
         idx      <= '0;
         S        <= '0;
         negativo <= 1'b0;
      end else begin
         unique case (estado)
            OCIOSO, PRONTO: begin
               if (inicia) begin
                  a_sh   <= A;
                  b_sh   <= B;
                  borrow <= 1'b0;
                  idx    <= '0;
                  if (invalido) begin
                     S        <= '0;
                     negativo <= 1'b0;
                  end
               end
            end
            SUBTRAI: begin
               a_sh <= a_sh >> 4;
               b_sh <= b_sh >> 4;
               res  <= res_next;
               if (ultimo) begin
                  idx    <= '0;
                  borrow <= 1'b0;
                  if (!bout) begin
                     S        <= res_next;
                     negativo <= 1'b0;
                  end
               end else begin
                  idx    <= idx + 1'b1;
                  borrow <= bout;
               end
            end
            COMPLEMENTA: begin
               res <= res_next;
               if (ultimo) begin
                  idx      <= '0;
                  borrow   <= 1'b0;
                  S        <= res_next;
                  negativo <= 1'b1;
               end else begin
                  idx    <= idx + 1'b1;
                  borrow <= bout;
               end
            end
            default: begin
               idx <= '0;
            end
         endcase
      end
   end

`ifdef SUBTRAI_BCD_VALIDA_EN
   // erro is raised by a rejected capture and cleared by the next real result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         erro <= 1'b0;
      end else if (inicia && invalido) begin
         erro <= 1'b1;
      end else if (carrega_s) begin
         erro <= 1'b0;
      end
   end
`else
   assign erro = 1'b0;
`endif

endmodule

// File: tb/tb_subtrai_bcd_serial.sv
// ---------------------------------------------------------------------------
// tb_subtrai_bcd_serial
// Scoreboard bench for subtrai_bcd_serial (DIGITOS=4). Each accepted start
// pushes the expected magnitude, sign, error flag and completion cycle,
// computed from integer arithmetic; a monitor pops and compares on valido.
// ---------------------------------------------------------------------------
module tb_subtrai_bcd_serial;

   localparam int D = 4;
   localparam int W = 4 * D;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         agora;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         ocupado;
   logic         valido;
   logic [W-1:0] S;
   logic         negativo;
   logic         erro;

   typedef struct {
      logic [W-1:0] s;
      logic         neg;
      logic         err;
      int           ciclo;
   } esperado_t;

   esperado_t fila[$];
   int        ciclo  = 0;
   int        checks = 0;
   int        errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) ciclo <= ciclo + 1;

   subtrai_bcd_serial #(.DIGITOS(D)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .agora    (agora),
      .A        (A),
      .B        (B),
      .ocupado  (ocupado),
      .valido   (valido),
      .S        (S),
      .negativo (negativo),
      .erro     (erro)
   );

   // Plain decimal conversions used by the reference model.
   function automatic int bcd2int(input logic [W-1:0] v);
      int n;
      n = 0;
      for (int i = D - 1; i >= 0; i--) n = n * 10 + int'(v[4*i +: 4]);
      return n;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int n);
      logic [W-1:0] r;
      int           m;
      r = '0;
      m = n;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   function automatic logic digito_ruim(input logic [W-1:0] v);
      logic r;
      r = 1'b0;
      for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) r = 1'b1;
      return r;
   endfunction

   task automatic checkOutput(input string nome, input logic [31:0] atual,
                              input logic [31:0] req);
      checks++;
      if (atual !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", nome, atual, req);
      end
   endtask

   // Starts one operation (caller sits just after a rising edge) and records
   // what the model says must come back and when.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
      esperado_t e;
      int        diff;
      diff    = bcd2int(a) - bcd2int(b);
      e.neg   = (diff < 0);
      e.s     = int2bcd(diff < 0 ? -diff : diff);
      e.err   = 1'b0;
      e.ciclo = ciclo + (e.neg ? 2 * D + 1 : D + 1);
`ifdef SUBTRAI_BCD_VALIDA_EN
      if (digito_ruim(a) || digito_ruim(b)) begin
         e.s     = '0;
         e.neg   = 1'b0;
         e.err   = 1'b1;
         e.ciclo = ciclo + 1;
      end
`endif
      fila.push_back(e);
      A     = a;
      B     = b;
      agora = 1'b1;
      @(posedge clk);
      #1;
      agora = 1'b0;
   endtask

   task automatic pulseIgnored(input logic [W-1:0] a, input logic [W-1:0] b);
      A     = a;
      B     = b;
      agora = 1'b1;
      @(posedge clk);
      #1;
      agora = 1'b0;
   endtask

   task automatic waitDone();
      for (int i = 0; i < 100; i++) begin
         if (fila.size() == 0) break;
         @(posedge clk);
         #1;
      end
      if (fila.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL timeout: %0d results still pending", fila.size());
         fila.delete();
      end
   endtask

   // Monitor: every valido pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && valido === 1'b1) begin
         if (fila.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_valido: got S=%h expected no result", S);
         end else begin
            esperado_t e;
            e = fila.pop_front();
            checkOutput("S", 32'(S), 32'(e.s));
            checkOutput("negativo", 32'(negativo), 32'(e.neg));
            checkOutput("erro", 32'(erro), 32'(e.err));
            checkOutput("latency_cycle", 32'(ciclo), 32'(e.ciclo));
         end
      end
   end

   initial begin
      int c0;
      int busy;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      rst_n = 1'b0;
      agora = 1'b0;
      A     = '0;
      B     = '0;
      #12;
      checkOutput("reset_S", 32'(S), 32'h0);
      checkOutput("reset_negativo", 32'(negativo), 32'h0);
      checkOutput("reset_erro", 32'(erro), 32'h0);
      checkOutput("reset_valido", 32'(valido), 32'h0);
      checkOutput("reset_ocupado", 32'(ocupado), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] directed: positive result and busy window");
      applyStimulus(16'h1234, 16'h0567);
      busy = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ocupado) busy++;
      end
      checkOutput("ocupado_cycles", 32'(busy), 32'd4);
      waitDone();

      $display("[TB] directed: negative and boundary results");
      applyStimulus(16'h0100, 16'h0250);
      waitDone();
      applyStimulus(16'h9999, 16'h9999);
      waitDone();
      applyStimulus(16'h0000, 16'h9999);
      waitDone();

      $display("[TB] directed: ignored start while busy, back-to-back start");
      c0 = ciclo;
      applyStimulus(16'h0000, 16'h0001);
      @(posedge clk);
      #1;
      pulseIgnored(16'h7777, 16'h1111);
      for (int i = 0; i < 20 && ciclo < c0 + 2 * D + 1; i++) begin
         @(posedge clk);
         #1;
      end
      applyStimulus(16'h0005, 16'h0003);
      waitDone();

      $display("[TB] directed: reset during subtraction");
      applyStimulus(16'h5000, 16'h0001);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_S", 32'(S), 32'h0);
      checkOutput("abort_negativo", 32'(negativo), 32'h0);
      checkOutput("abort_valido", 32'(valido), 32'h0);
      checkOutput("abort_ocupado", 32'(ocupado), 32'h0);
      fila.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      applyStimulus(16'h0042, 16'h0017);
      waitDone();

`ifdef SUBTRAI_BCD_VALIDA_EN
      $display("[TB] directed: invalid digit rejection");
      applyStimulus(16'h12A4, 16'h0001);
      waitDone();
      applyStimulus(16'h0003, 16'h0001);
      waitDone();
`endif

      $display("[TB] random operations");
      for (int n = 0; n < 30; n++) begin
         ra = int2bcd(int'($urandom_range(0, 9999)));
         rb = (n % 7 == 3) ? ra : int2bcd(int'($urandom_range(0, 9999)));
         applyStimulus(ra, rb);
         waitDone();
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      waitDone();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
